// File: rtl/run_detector_if.sv
// Bus bundle for run_detector: serial stream input, controls and detector results.
interface run_detector_if #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8,
  parameter int LW      = $clog2(RUN_LEN + 1)
);
  logic             stream;
  logic             stream_valid;
  logic [1:0]       mode;
  logic             overlap;
  logic             clr_cnt;
  logic             out;
  logic             hit_bit;
  logic [LW-1:0]    run_len;
  logic [CNT_W-1:0] det_cnt;

  modport master (
    output stream, stream_valid, mode, overlap, clr_cnt,
    input  out, hit_bit, run_len, det_cnt
  );

  modport slave (
    input  stream, stream_valid, mode, overlap, clr_cnt,
    output out, hit_bit, run_len, det_cnt
  );
endinterface

// File: rtl/run_detector.sv
// Detects runs of RUN_LEN equal bits on a qualified serial stream, with value
// filtering, overlapping/non-overlapping hit counting and a saturating hit counter.
module run_detector #(
  parameter  int RUN_LEN = 2,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(RUN_LEN + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  run_detector_if.slave bus
);

  // One-hot style encoding leaves illegal codes that must fall back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RUN  = 2'b10
  } state_e;

  localparam logic [LW-1:0]    RUN_LEN_L = LW'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    len_inc_s;
  logic             out_q, out_d;
  logic             hb_q, hb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             permit_s;
  logic             hit_s;

  // Mode filter on the value of the current run.
  always_comb begin
    permit_s = 1'b0;
    case (bus.mode)
      2'b00:   permit_s = 1'b1;
      2'b01:   permit_s = ~last_q;
      2'b10:   permit_s = last_q;
      default: permit_s = 1'b0;
    endcase
  end

  // Next-state, run tracking and hit/counter logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    len_d     = len_q;
    out_d     = 1'b0;
    hb_d      = hb_q;
    cnt_d     = cnt_q;
    hit_s     = 1'b0;
    len_inc_s = (len_q >= RUN_LEN_L) ? RUN_LEN_L : len_q + LW'(1);
    case (state_q)
      IDLE: begin
        if (bus.stream_valid) begin
          state_d = RUN;
          last_d  = bus.stream;
          len_d   = LW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.stream_valid) begin
          if (bus.stream != last_q) begin
            last_d = bus.stream;
            len_d  = LW'(1);
          end else if ((len_inc_s == RUN_LEN_L) && permit_s) begin
            hit_s = 1'b1;
            len_d = bus.overlap ? RUN_LEN_L : LW'(0);
          end else begin
            // Filtered runs park at RUN_LEN so a later mode change can hit at once.
            len_d = len_inc_s;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (hit_s) begin
      out_d = 1'b1;
      hb_d  = last_q;
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end else begin
      out_d = 1'b0;
    end

    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      len_q   <= '0;
      out_q   <= 1'b0;
      hb_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      len_q   <= len_d;
      out_q   <= out_d;
      hb_q    <= hb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.hit_bit = hb_q;
  assign bus.run_len = len_q;
  assign bus.det_cnt = cnt_q;

endmodule
